// File: rtl/i2c_slave_ctrl.sv
// I2C target responder: oversamples SCL/SDA, matches a 7-bit address, delivers written
// bytes on a strobe and fetches read bytes from a TX-FIFO-style interface. Open-drain SDA.
module i2c_slave_ctrl #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  inout  wire        sda,
  input  logic [7:0] tx_data,
  output logic       tx_rd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP
  } state_t;

  state_t     state, state_nxt;
  logic       scl_s1, scl_s2, scl_d;
  logic       sda_s1, sda_s2, sda_d;
  logic [2:0] bit_cnt, bit_cnt_nxt;
  logic [7:0] shift, shift_nxt;
  logic [7:0] tx_shift, tx_shift_nxt;
  logic       full, full_nxt;     // byte received / master ACK seen, acted on at next scl_fall
  logic       rw, rw_nxt;
  logic       sda_oe, sda_oe_nxt;
  logic       busy_nxt, tx_rd_nxt, rx_valid_nxt;
  logic [7:0] rx_data_nxt;

  logic scl_rise, scl_fall, start_cond, stop_cond;

  assign scl_rise   =  scl_s2 & ~scl_d;
  assign scl_fall   = ~scl_s2 &  scl_d;
  assign start_cond =  scl_s2 & scl_d &  sda_d & ~sda_s2;
  assign stop_cond  =  scl_s2 & scl_d & ~sda_d &  sda_s2;

  assign sda = sda_oe ? 1'b0 : 1'bz;

  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: synchronizers reset to 1 so the idle bus does not look like a START on exit.
      scl_s1   <= 1'b1;
      scl_s2   <= 1'b1;
      scl_d    <= 1'b1;
      sda_s1   <= 1'b1;
      sda_s2   <= 1'b1;
      sda_d    <= 1'b1;
      state    <= IDLE;
      bit_cnt  <= 3'd0;
      shift    <= 8'h00;
      tx_shift <= 8'h00;
      full     <= 1'b0;
      rw       <= 1'b0;
      sda_oe   <= 1'b0;
      busy     <= 1'b0;
      tx_rd    <= 1'b0;
      rx_valid <= 1'b0;
      rx_data  <= 8'h00;
    end else begin
      scl_s1   <= scl;
      scl_s2   <= scl_s1;
      scl_d    <= scl_s2;
      sda_s1   <= sda;
      sda_s2   <= sda_s1;
      sda_d    <= sda_s2;
      state    <= state_nxt;
      bit_cnt  <= bit_cnt_nxt;
      shift    <= shift_nxt;
      tx_shift <= tx_shift_nxt;
      full     <= full_nxt;
      rw       <= rw_nxt;
      sda_oe   <= sda_oe_nxt;
      busy     <= busy_nxt;
      tx_rd    <= tx_rd_nxt;
      rx_valid <= rx_valid_nxt;
      rx_data  <= rx_data_nxt;
    end
  end

  always_comb begin
    // NOTE: every next-value gets a default first so no path leaves a latch behind.
    state_nxt    = state;
    bit_cnt_nxt  = bit_cnt;
    shift_nxt    = shift;
    tx_shift_nxt = tx_shift;
    full_nxt     = full;
    rw_nxt       = rw;
    sda_oe_nxt   = sda_oe;
    busy_nxt     = busy;
    rx_data_nxt  = rx_data;
    tx_rd_nxt    = 1'b0;
    rx_valid_nxt = 1'b0;

    if (stop_cond) begin
      state_nxt   = IDLE;
      sda_oe_nxt  = 1'b0;
      busy_nxt    = 1'b0;
      bit_cnt_nxt = 3'd0;
      full_nxt    = 1'b0;
    end else if (start_cond) begin
      state_nxt   = ADDR;
      sda_oe_nxt  = 1'b0;
      busy_nxt    = 1'b0;
      bit_cnt_nxt = 3'd0;
      full_nxt    = 1'b0;
    end else begin
      unique case (state)
        IDLE, WAIT_STOP: ;
        ADDR, WR_DATA: begin
          if (scl_rise) begin
            shift_nxt = {shift[6:0], sda_s2};
            if (bit_cnt == 3'd7) begin
              bit_cnt_nxt = 3'd0;
              full_nxt    = 1'b1;
            end else begin
              bit_cnt_nxt = bit_cnt + 3'd1;
            end
          end else if (scl_fall && full) begin
            full_nxt = 1'b0;
            if (state == WR_DATA) begin
              rx_data_nxt  = shift;
              rx_valid_nxt = 1'b1;
              sda_oe_nxt   = 1'b1;
              state_nxt    = WR_ACK;
            end else if (shift[7:1] == SLAVE_ADDR) begin
              rw_nxt     = shift[0];
              sda_oe_nxt = 1'b1;
              busy_nxt   = 1'b1;
              state_nxt  = ADDR_ACK;
            end else begin
              sda_oe_nxt = 1'b0;
              state_nxt  = WAIT_STOP;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            bit_cnt_nxt = 3'd0;
            if (!rw) begin
              sda_oe_nxt = 1'b0;
              state_nxt  = WR_DATA;
            end else begin
              tx_shift_nxt = tx_data;
              tx_rd_nxt    = 1'b1;
              sda_oe_nxt   = ~tx_data[7];
              state_nxt    = RD_DATA;
            end
          end
        end
        WR_ACK: begin
          if (scl_fall) begin
            sda_oe_nxt  = 1'b0;
            bit_cnt_nxt = 3'd0;
            state_nxt   = WR_DATA;
          end
        end
        RD_DATA: begin
          if (scl_fall) begin
            if (bit_cnt == 3'd7) begin
              sda_oe_nxt  = 1'b0;
              bit_cnt_nxt = 3'd0;
              full_nxt    = 1'b0;
              state_nxt   = RD_ACK;
            end else begin
              tx_shift_nxt = {tx_shift[6:0], 1'b0};
              sda_oe_nxt   = ~tx_shift[6];
              bit_cnt_nxt  = bit_cnt + 3'd1;
            end
          end
        end
        RD_ACK: begin
          if (scl_rise) begin
            if (sda_s2) state_nxt = WAIT_STOP;
            else        full_nxt  = 1'b1;
          end else if (scl_fall && full) begin
            full_nxt     = 1'b0;
            tx_shift_nxt = tx_data;
            tx_rd_nxt    = 1'b1;
            sda_oe_nxt   = ~tx_data[7];
            bit_cnt_nxt  = 3'd0;
            state_nxt    = RD_DATA;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_slave_ctrl.sv
// Directed bench for i2c_slave_ctrl: a bit-banged bus master, a write-vector table and
// hand-written read / repeated-START / reset / aborted-byte sequences.
module tb_i2c_slave_ctrl;

  localparam int Q = 5;  // quarter SCL period in clk cycles

  logic       clk = 1'b0;
  logic       rst;
  logic       m_scl;
  logic       m_sda_low;
  logic [7:0] tx_data;
  logic       tx_rd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  wire        sda;

  pullup (sda);
  assign sda = m_sda_low ? 1'b0 : 1'bz;

  i2c_slave_ctrl #(.SLAVE_ADDR(7'h50)) dut (
    .clk      (clk),
    .rst      (rst),
    .scl      (m_scl),
    .sda      (sda),
    .tx_data  (tx_data),
    .tx_rd    (tx_rd),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         rx_cnt  = 0;
  int         tx_cnt  = 0;
  int         busy_cyc = 0;
  logic [7:0] rx_q[$];

  always @(negedge clk) begin
    if (rx_valid) begin
      rx_cnt++;
      rx_q.push_back(rx_data);
    end
    if (tx_rd) tx_cnt++;
    if (busy)  busy_cyc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_bit(input logic b, output logic r);
    m_sda_low = ~b;
    wait_clks(Q);
    m_scl = 1'b1;
    wait_clks(Q);
    r = sda;
    wait_clks(Q);
    m_scl = 1'b0;
    wait_clks(Q);
  endtask

  task automatic bus_start;
    m_sda_low = 1'b1;
    wait_clks(Q);
    m_scl = 1'b0;
    wait_clks(Q);
  endtask

  task automatic bus_rstart;
    m_sda_low = 1'b0;
    wait_clks(Q);
    m_scl = 1'b1;
    wait_clks(Q);
    m_sda_low = 1'b1;
    wait_clks(Q);
    m_scl = 1'b0;
    wait_clks(Q);
  endtask

  // b2/b3: busy seen 2 and 3 clk after the SDA rise that forms the STOP.
  task automatic bus_stop(output logic b2, output logic b3);
    m_sda_low = 1'b1;
    wait_clks(Q);
    m_scl = 1'b1;
    wait_clks(Q);
    m_sda_low = 1'b0;
    wait_clks(2);
    b2 = busy;
    wait_clks(1);
    b3 = busy;
    wait_clks(Q);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bus_bit(b[i], r);
    bus_bit(1'b1, r);
    ack = ~r;
  endtask

  task automatic read_byte(input logic master_ack, input logic [7:0] next_tx,
                           output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bus_bit(1'b1, r);
      d[i] = r;
    end
    tx_data = next_tx;
    bus_bit(~master_ack, r);
  endtask

  typedef struct {
    logic [6:0] addr;
    logic [7:0] data;
    logic       exp_ack;
  } wr_vec_t;

  wr_vec_t vecs[5];

  initial begin
    logic       ack, b2, b3, r;
    logic [7:0] d;
    int         rx_base, tx_base, busy_base;

    vecs[0] = '{addr: 7'h50, data: 8'h5A, exp_ack: 1'b1};
    vecs[1] = '{addr: 7'h51, data: 8'h77, exp_ack: 1'b0};
    vecs[2] = '{addr: 7'h50, data: 8'h00, exp_ack: 1'b1};
    vecs[3] = '{addr: 7'h28, data: 8'hC3, exp_ack: 1'b0};
    vecs[4] = '{addr: 7'h50, data: 8'hFF, exp_ack: 1'b1};

    rst = 1'b0;
    m_scl = 1'b1;
    m_sda_low = 1'b0;
    tx_data = 8'h00;
    wait_clks(4);
    check("reset sda released", {31'd0, sda}, 32'd1);
    check("reset tx_rd", {31'd0, tx_rd}, 32'd0);
    check("reset rx_valid", {31'd0, rx_valid}, 32'd0);
    check("reset rx_data", {24'd0, rx_data}, 32'h00);
    check("reset busy", {31'd0, busy}, 32'd0);
    rst = 1'b1;
    wait_clks(4);

    // Two-byte write with busy release timing
    rx_base = rx_cnt;
    bus_start();
    write_byte(8'hA0, ack);
    check("wr2 addr ack", {31'd0, ack}, 32'd1);
    write_byte(8'hA5, ack);
    check("wr2 byte0 ack", {31'd0, ack}, 32'd1);
    write_byte(8'h3C, ack);
    check("wr2 byte1 ack", {31'd0, ack}, 32'd1);
    check("wr2 busy before stop", {31'd0, busy}, 32'd1);
    bus_stop(b2, b3);
    check("wr2 busy 2clk after stop", {31'd0, b2}, 32'd1);
    check("wr2 busy 3clk after stop", {31'd0, b3}, 32'd0);
    check("wr2 rx_valid count", rx_cnt - rx_base, 32'd2);
    check("wr2 rx byte0", {24'd0, rx_q[rx_base]}, 32'hA5);
    check("wr2 rx byte1", {24'd0, rx_q[rx_base+1]}, 32'h3C);

    // Single-byte writes to matching and non-matching addresses
    for (int i = 0; i < 5; i++) begin
      rx_base = rx_cnt;
      busy_base = busy_cyc;
      bus_start();
      write_byte({vecs[i].addr, 1'b0}, ack);
      check($sformatf("vec%0d addr ack", i), {31'd0, ack}, {31'd0, vecs[i].exp_ack});
      write_byte(vecs[i].data, ack);
      check($sformatf("vec%0d data ack", i), {31'd0, ack}, {31'd0, vecs[i].exp_ack});
      bus_stop(b2, b3);
      check($sformatf("vec%0d busy at stop", i), {31'd0, b2}, {31'd0, vecs[i].exp_ack});
      check($sformatf("vec%0d busy seen", i), {31'd0, busy_cyc != busy_base},
            {31'd0, vecs[i].exp_ack});
      check($sformatf("vec%0d rx count", i), rx_cnt - rx_base, {31'd0, vecs[i].exp_ack});
      if (vecs[i].exp_ack)
        check($sformatf("vec%0d rx data", i), {24'd0, rx_q[rx_base]}, {24'd0, vecs[i].data});
      wait_clks(4);
    end

    // Two-byte read, master ACKs the first and NACKs the second
    tx_base = tx_cnt;
    tx_data = 8'h96;
    bus_start();
    write_byte(8'hA1, ack);
    check("rd addr ack", {31'd0, ack}, 32'd1);
    read_byte(1'b1, 8'h0F, d);
    check("rd byte0", {24'd0, d}, 32'h96);
    read_byte(1'b0, 8'hEE, d);
    check("rd byte1", {24'd0, d}, 32'h0F);
    wait_clks(2);
    check("rd sda released after nack", {31'd0, sda}, 32'd1);
    check("rd tx_rd count", tx_cnt - tx_base, 32'd2);
    bus_stop(b2, b3);
    check("rd busy after stop", {31'd0, b3}, 32'd0);
    wait_clks(4);

    // Write, repeated START, read
    rx_base = rx_cnt;
    tx_base = tx_cnt;
    tx_data = 8'h7E;
    bus_start();
    write_byte(8'hA0, ack);
    write_byte(8'h11, ack);
    check("sr write ack", {31'd0, ack}, 32'd1);
    bus_rstart();
    write_byte(8'hA1, ack);
    check("sr read addr ack", {31'd0, ack}, 32'd1);
    read_byte(1'b0, 8'h00, d);
    check("sr read data", {24'd0, d}, 32'h7E);
    bus_stop(b2, b3);
    check("sr rx count", rx_cnt - rx_base, 32'd1);
    check("sr rx data", {24'd0, rx_q[rx_base]}, 32'h11);
    check("sr tx_rd count", tx_cnt - tx_base, 32'd1);
    wait_clks(4);

    // Reset while the slave drives bit 4 of a read byte
    tx_data = 8'h00;
    bus_start();
    write_byte(8'hA1, ack);
    for (int i = 0; i < 3; i++) bus_bit(1'b1, r);
    m_sda_low = 1'b0;
    wait_clks(Q);
    m_scl = 1'b1;
    wait_clks(Q);
    check("rst slave drives bit4", {31'd0, sda}, 32'd0);
    rst = 1'b0;
    wait_clks(1);
    check("rst sda released", {31'd0, sda}, 32'd1);
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst rx_data", {24'd0, rx_data}, 32'h00);
    check("rst tx_rd", {31'd0, tx_rd}, 32'd0);
    check("rst rx_valid", {31'd0, rx_valid}, 32'd0);
    rst = 1'b1;
    wait_clks(2);
    m_scl = 1'b0;
    wait_clks(Q);
    bus_stop(b2, b3);
    wait_clks(4);
    rx_base = rx_cnt;
    bus_start();
    write_byte(8'hA0, ack);
    check("post-rst addr ack", {31'd0, ack}, 32'd1);
    write_byte(8'h69, ack);
    bus_stop(b2, b3);
    check("post-rst rx data", {24'd0, rx_q[rx_base]}, 32'h69);
    wait_clks(4);

    // STOP after 5 bits of a write byte discards it
    rx_base = rx_cnt;
    bus_start();
    write_byte(8'hA0, ack);
    for (int i = 0; i < 5; i++) bus_bit(i[0], r);
    bus_stop(b2, b3);
    check("abort no rx_valid", rx_cnt - rx_base, 32'd0);
    check("abort sda released", {31'd0, sda}, 32'd1);
    check("abort busy", {31'd0, b3}, 32'd0);
    wait_clks(4);
    bus_start();
    write_byte(8'hA0, ack);
    write_byte(8'h22, ack);
    check("abort retry ack", {31'd0, ack}, 32'd1);
    bus_stop(b2, b3);
    check("abort retry rx count", rx_cnt - rx_base, 32'd1);
    check("abort retry rx data", {24'd0, rx_data}, 32'h22);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
